// File: rtl/pc_sequencer_if.sv
// Fetch-stage control bundle between the control decoder (master) and the
// program-counter sequencer (slave).
interface pc_sequencer_if #(
  parameter int ADDR_W      = 13,
  parameter int STACK_DEPTH = 8,
  parameter int OFF_W       = 8
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                stall;
  logic [2:0]          op;
  logic [ADDR_W-1:0]   target;
  logic [OFF_W-1:0]    offset;
  logic                clrErr;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   stackTop;
  logic [DEPTH_W-1:0]  depth;
  logic                full;
  logic                empty;
  logic                overflow;
  logic                underflow;

  modport master (
    output stall, op, target, offset, clrErr,
    input  pc, stackTop, depth, full, empty, overflow, underflow
  );

  modport slave (
    input  stall, op, target, offset, clrErr,
    output pc, stackTop, depth, full, empty, overflow, underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a hardware call/return stack and sticky
// overflow/underflow flags. Define PCSEQ_REL_BRANCH_EN to enable relative branches.
module pc_sequencer #(
  parameter int                ADDR_W      = 13,
  parameter int                STACK_DEPTH = 8,
  parameter int                OFF_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input logic          i_clk,
  input logic          i_rst,
  pc_sequencer_if.slave bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_JMP    = 3'b010,
    OP_BRANCH = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101
  } op_e;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

  logic               full, empty, push;
  logic [IDX_W-1:0]   topIdx, pushIdx;
  logic [ADDR_W-1:0]  pcInc, stackTop;

  assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth_q == '0);
  assign topIdx   = IDX_W'(depth_q - DEPTH_W'(1));
  assign pushIdx  = IDX_W'(depth_q);
  assign pcInc    = pc_q + ADDR_W'(1);
  assign stackTop = empty ? '0 : stack_q[topIdx];

`ifdef PCSEQ_REL_BRANCH_EN
  logic [ADDR_W-1:0] offExt;
  assign offExt = ADDR_W'($signed(bus.offset));
`else
  // Offset is deliberately ignored when relative branches are compiled out.
  logic unusedOffset;
  assign unusedOffset = ^bus.offset;
`endif

  always_comb begin
    pc_d        = pc_q;
    depth_d     = depth_q;
    push        = 1'b0;
    overflow_d  = overflow_q & ~bus.clrErr;
    underflow_d = underflow_q & ~bus.clrErr;
    if (!bus.stall) begin
      case (bus.op)
        OP_INC: pc_d = pcInc;
        OP_JMP: pc_d = bus.target;
`ifdef PCSEQ_REL_BRANCH_EN
        OP_BRANCH: pc_d = pc_q + offExt;
`else
        OP_BRANCH: pc_d = pcInc;
`endif
        OP_CALL: begin
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            push    = 1'b1;
            depth_d = depth_q + DEPTH_W'(1);
            pc_d    = bus.target;
          end
        end
        OP_RET: begin
          if (empty) begin
            underflow_d = 1'b1;
          end else begin
            pc_d    = stackTop;
            depth_d = depth_q - DEPTH_W'(1);
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q        <= RESET_VEC;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; an empty stack masks stale contents on stackTop.
  always_ff @(posedge i_clk) begin
    if (push) begin
      stack_q[pushIdx] <= pcInc;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.depth     = depth_q;
  assign bus.stackTop  = stackTop;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: expected states are queued as each
// op is driven and popped for comparison one clock later.
module tb_pc_sequencer;
  localparam int          ADDR_W      = 13;
  localparam int          STACK_DEPTH = 8;
  localparam int          OFF_W       = 8;
  localparam logic [12:0] RESET_VEC   = 13'h100;

  localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, JMP = 3'b010;
  localparam logic [2:0] BRANCH = 3'b011, CALL = 3'b100, RET = 3'b101, RSVD = 3'b110;

  typedef struct {
    string       tag;
    logic [12:0] pc;
    logic [3:0]  depth;
    logic [12:0] top;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sbQ[$];
  int   assertCount;
  int   failCount;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .OFF_W(OFF_W)) pcIf ();

  pc_sequencer #(
    .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .OFF_W(OFF_W), .RESET_VEC(RESET_VEC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (pcIf.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [12:0] pc, input logic [3:0] depth,
                         input logic [12:0] top, input logic ovf, input logic unf);
    exp_t e;
    e.tag = tag; e.pc = pc; e.depth = depth; e.top = top; e.ovf = ovf; e.unf = unf;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sbQ.pop_front();
    cmp({e.tag, ".pc"},        32'(pcIf.pc),        32'(e.pc));
    cmp({e.tag, ".depth"},     32'(pcIf.depth),     32'(e.depth));
    cmp({e.tag, ".stackTop"},  32'(pcIf.stackTop),  32'(e.top));
    cmp({e.tag, ".full"},      32'(pcIf.full),      32'(e.depth == 4'd8));
    cmp({e.tag, ".empty"},     32'(pcIf.empty),     32'(e.depth == 4'd0));
    cmp({e.tag, ".overflow"},  32'(pcIf.overflow),  32'(e.ovf));
    cmp({e.tag, ".underflow"}, 32'(pcIf.underflow), 32'(e.unf));
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [12:0] tgt, input logic [7:0] off,
                               input logic stall, input logic clr);
    pcIf.op     = op;
    pcIf.target = tgt;
    pcIf.offset = off;
    pcIf.stall  = stall;
    pcIf.clrErr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [2:0] op, input logic [12:0] tgt,
                      input logic [7:0] off, input logic stall, input logic clr,
                      input logic [12:0] pc, input logic [3:0] depth, input logic [12:0] top,
                      input logic ovf, input logic unf);
    pushExp(tag, pc, depth, top, ovf, unf);
    applyStimulus(op, tgt, off, stall, clr);
    checkOutput();
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst = 1'b1;
    pcIf.op = HOLD; pcIf.target = '0; pcIf.offset = '0; pcIf.stall = 1'b0; pcIf.clrErr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pushExp("reset", 13'h100, 4'd0, 13'h000, 1'b0, 1'b0);
    checkOutput();
    rst = 1'b0;

    step("inc1", INC, 0, 0, 0, 0, 13'h101, 0, 0, 0, 0);
    step("inc2", INC, 0, 0, 0, 0, 13'h102, 0, 0, 0, 0);
    step("inc3", INC, 0, 0, 0, 0, 13'h103, 0, 0, 0, 0);
    step("rsvd", RSVD, 13'h0AAA, 0, 0, 0, 13'h103, 0, 0, 0, 0);

    step("jmpTop", JMP, 13'h1FFF, 0, 0, 0, 13'h1FFF, 0, 0, 0, 0);
    step("incWrap", INC, 0, 0, 0, 0, 13'h0000, 0, 0, 0, 0);
    step("jmp10", JMP, 13'h0010, 0, 0, 0, 13'h0010, 0, 0, 0, 0);
`ifdef PCSEQ_REL_BRANCH_EN
    step("brNeg", BRANCH, 0, 8'hF0, 0, 0, 13'h0000, 0, 0, 0, 0);
    step("brPos", BRANCH, 0, 8'h05, 0, 0, 13'h0005, 0, 0, 0, 0);
`else
    step("brNeg", BRANCH, 0, 8'hF0, 0, 0, 13'h0011, 0, 0, 0, 0);
    step("brPos", BRANCH, 0, 8'h05, 0, 0, 13'h0012, 0, 0, 0, 0);
`endif

    // Nested calls with one INC inside each routine before the next call.
    step("jmpMain", JMP, 13'h010, 0, 0, 0, 13'h010, 0, 0, 0, 0);
    step("call200", CALL, 13'h200, 0, 0, 0, 13'h200, 1, 13'h011, 0, 0);
    step("inc200", INC, 0, 0, 0, 0, 13'h201, 1, 13'h011, 0, 0);
    step("call300", CALL, 13'h300, 0, 0, 0, 13'h300, 2, 13'h202, 0, 0);
    step("inc300", INC, 0, 0, 0, 0, 13'h301, 2, 13'h202, 0, 0);
    step("call400", CALL, 13'h400, 0, 0, 0, 13'h400, 3, 13'h302, 0, 0);
    step("ret1", RET, 0, 0, 0, 0, 13'h302, 2, 13'h202, 0, 0);
    step("ret2", RET, 0, 0, 0, 0, 13'h202, 1, 13'h011, 0, 0);
    step("ret3", RET, 0, 0, 0, 0, 13'h011, 0, 13'h000, 0, 0);
    step("callRet", CALL, 13'h555, 0, 0, 0, 13'h555, 1, 13'h012, 0, 0);
    step("retBack", RET, 0, 0, 0, 0, 13'h012, 0, 13'h000, 0, 0);

    step("fill0", CALL, 13'h1000, 0, 0, 0, 13'h1000, 1, 13'h013, 0, 0);
    for (int i = 1; i < 8; i++) begin
      step($sformatf("fill%0d", i), CALL, 13'(13'h1000 + i), 0, 0, 0,
           13'(13'h1000 + i), 4'(i + 1), 13'(13'h1000 + i), 0, 0);
    end
    step("callFull", CALL, 13'h0ABC, 0, 0, 0, 13'h1007, 8, 13'h1007, 1, 0);
    step("clrOvf", HOLD, 0, 0, 0, 1, 13'h1007, 8, 13'h1007, 0, 0);
    step("setWins", CALL, 13'h0ABC, 0, 0, 1, 13'h1007, 8, 13'h1007, 1, 0);
    step("clrStall", CALL, 13'h0ABC, 0, 1, 1, 13'h1007, 8, 13'h1007, 0, 0);
    for (int i = 7; i >= 1; i--) begin
      step($sformatf("drain%0d", i), RET, 0, 0, 0, 0,
           13'(13'h1000 + i), 4'(i), (i == 1) ? 13'h013 : 13'(13'h1000 + i - 1), 0, 0);
    end
    step("drain0", RET, 0, 0, 0, 0, 13'h013, 0, 13'h000, 0, 0);
    step("retEmpty", RET, 0, 0, 0, 0, 13'h013, 0, 13'h000, 0, 1);
    step("clrUnf", HOLD, 0, 0, 0, 1, 13'h013, 0, 13'h000, 0, 0);

    step("stallRet", RET, 0, 0, 1, 0, 13'h013, 0, 13'h000, 0, 0);
    step("stallCall", CALL, 13'h0777, 0, 1, 0, 13'h013, 0, 13'h000, 0, 0);
    step("stallInc", INC, 0, 0, 1, 0, 13'h013, 0, 13'h000, 0, 0);

    step("callPreRst", CALL, 13'h0777, 0, 0, 0, 13'h0777, 1, 13'h014, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    pushExp("asyncRst", 13'h100, 4'd0, 13'h000, 1'b0, 1'b0);
    checkOutput();
    pcIf.op = HOLD;
    #2;
    rst = 1'b0;
    step("afterRst", INC, 0, 0, 0, 0, 13'h101, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
